// File: rtl/store_align_buffer.sv
// Memory-stage store unit: aligns stores to word lanes and queues them
// in a small FIFO that drains to data memory over valid/ready.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   st_valid/st_ready   store request handshake (ready = not full)
//   st_addr/st_data     byte address and right-justified store data
//   st_size             00 byte, 01 half, 10/11 word
//   dmem_wr_*           head entry: word address, lane data, byte enables
//   sb_empty, sb_count  buffer occupancy
//   misalign_trap       only with BANFF_STORE_MISALIGN_TRAP_EN defined:
//                       one-cycle pulse after a misaligned store is dropped
module store_align_buffer #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [XLEN-1:0]            st_data,
  input  logic [1:0]                 st_size,
  output logic                       dmem_wr_valid,
  input  logic                       dmem_wr_ready,
  output logic [ADDR_W-1:0]          dmem_wr_addr,
  output logic [XLEN-1:0]            dmem_wr_data,
  output logic [3:0]                 dmem_wr_be,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count
`ifdef BANFF_STORE_MISALIGN_TRAP_EN
  ,
  output logic                       misalign_trap
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [3:0]        be;
  } sb_entry_t;

  sb_entry_t         mem_q [DEPTH];
  sb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic [1:0]        off;
  sb_entry_t         new_ent;
  logic              accept;
  logic              enq;
  logic              deq;

  // ---------------- alignment ----------------
  assign off     = st_addr[1:0];
  assign is_byte = (st_size == 2'b00);
  assign is_half = (st_size == 2'b01);
  assign is_word = st_size[1];

  always_comb begin
    new_ent      = '0;
    new_ent.addr = {st_addr[ADDR_W-1:2], 2'b00};
    unique case (1'b1)
      is_byte: begin
        new_ent.be   = 4'b0001 << off;
        new_ent.data = {4{st_data[7:0]}};
      end
      is_half: begin
        new_ent.be   = off[1] ? 4'b1100 : 4'b0011;
        new_ent.data = {2{st_data[15:0]}};
      end
      is_word: begin
        new_ent.be   = 4'b1111;
        new_ent.data = st_data;
      end
      default: begin
        new_ent.be   = 4'b1111;
        new_ent.data = st_data;
      end
    endcase
  end

  // ---------------- handshakes ----------------
  assign st_ready      = (count_q < CW'(DEPTH));
  assign sb_empty      = (count_q == '0);
  assign sb_count      = count_q;
  assign dmem_wr_valid = !sb_empty;
  assign accept        = st_valid && st_ready;
  assign deq           = dmem_wr_valid && dmem_wr_ready;

`ifdef BANFF_STORE_MISALIGN_TRAP_EN
  logic misaligned;
  logic trap_q, trap_d;

  // Misaligned stores complete the handshake but never reach memory.
  assign misaligned = (is_half && off[0]) ||
                      (is_word && (off != 2'b00));
  assign enq        = accept && !misaligned;
  assign trap_d     = accept && misaligned;
  assign misalign_trap = trap_q;

  always_ff @(posedge clock) begin
    if (!reset) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end
`else
  assign enq = accept;
`endif

  // ---------------- head outputs ----------------
  // Gated by valid so the bus reads zero whenever the buffer is empty.
  always_comb begin
    dmem_wr_addr = '0;
    dmem_wr_data = '0;
    dmem_wr_be   = '0;
    if (dmem_wr_valid) begin
      dmem_wr_addr = mem_q[rd_ptr_q].addr;
      dmem_wr_data = mem_q[rd_ptr_q].data;
      dmem_wr_be   = mem_q[rd_ptr_q].be;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = new_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // enq only when not full, deq only when not empty: stays in 0..DEPTH
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed self-checking bench for store_align_buffer.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_store_align_buffer;

  logic        clock;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        dmem_wr_valid;
  logic        dmem_wr_ready;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic [3:0]  dmem_wr_be;
  logic        sb_empty;
  logic [2:0]  sb_count;
`ifdef BANFF_STORE_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int total = 0;
  int bad   = 0;

  store_align_buffer #(
    .XLEN(32), .ADDR_W(32), .DEPTH(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_size       (st_size),
    .dmem_wr_valid (dmem_wr_valid),
    .dmem_wr_ready (dmem_wr_ready),
    .dmem_wr_addr  (dmem_wr_addr),
    .dmem_wr_data  (dmem_wr_data),
    .dmem_wr_be    (dmem_wr_be),
    .sb_empty      (sb_empty),
    .sb_count      (sb_count)
`ifdef BANFF_STORE_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  initial begin
    reset         = 1'b0;
    st_valid      = 1'b0;
    st_addr       = '0;
    st_data       = '0;
    st_size       = '0;
    dmem_wr_ready = 1'b0;
    step();
    step();

    // reset state
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_valid", 32'(dmem_wr_valid), 32'd0);
    chk("rst_addr", dmem_wr_addr, 32'd0);
    chk("rst_data", dmem_wr_data, 32'd0);
    chk("rst_be", 32'(dmem_wr_be), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    reset = 1'b1;
    step();

    // byte stores 0x1000..0x1003, streaming with ready=1
    dmem_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h1000 + 32'(i), 32'h0000_00A5, 2'b00);
      step();
      chk("byte_valid", 32'(dmem_wr_valid), 32'd1);
      chk("byte_addr", dmem_wr_addr, 32'h1000);
      chk("byte_be", 32'(dmem_wr_be), 32'(4'b0001 << i));
      chk("byte_data", dmem_wr_data, 32'hA5A5_A5A5);
      chk("byte_count", 32'(sb_count), 32'd1);
    end
    st_valid = 1'b0;
    step();
    chk("byte_drained", 32'(sb_empty), 32'd1);

    // half then word
    offer(32'h2002, 32'h0000_BEEF, 2'b01);
    step();
    chk("half_addr", dmem_wr_addr, 32'h2000);
    chk("half_be", 32'(dmem_wr_be), 32'hC);
    chk("half_data", dmem_wr_data, 32'hBEEF_BEEF);
    offer(32'h2004, 32'h1234_5678, 2'b10);
    step();
    chk("word_addr", dmem_wr_addr, 32'h2004);
    chk("word_be", 32'(dmem_wr_be), 32'hF);
    chk("word_data", dmem_wr_data, 32'h1234_5678);
    st_valid = 1'b0;
    step();
    chk("hw_drained", 32'(dmem_wr_valid), 32'd0);

    // fill with memory stalled
    dmem_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(32'h4000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 2'b10);
      chk("fill_ready", 32'(st_ready), 32'd1);
      step();
    end
    chk("full_count", 32'(sb_count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    offer(32'h4010, 32'h1111_0004, 2'b10);
    step();
    step();
    chk("stall_count", 32'(sb_count), 32'd4);
    chk("stall_valid", 32'(dmem_wr_valid), 32'd1);
    chk("stall_addr", dmem_wr_addr, 32'h4000);
    chk("stall_data", dmem_wr_data, 32'h1111_0000);

    // full + dequeue same edge: no enqueue
    dmem_wr_ready = 1'b1;
    step();
    chk("fd_count", 32'(sb_count), 32'd3);
    chk("fd_ready", 32'(st_ready), 32'd1);
    chk("fd_data1", dmem_wr_data, 32'h1111_0001);
    step();
    st_valid = 1'b0;
    chk("fd_count2", 32'(sb_count), 32'd3);
    chk("fd_data2", dmem_wr_data, 32'h1111_0002);
    step();
    chk("fd_data3", dmem_wr_data, 32'h1111_0003);
    chk("fd_count3", 32'(sb_count), 32'd2);
    step();
    chk("fd_data4", dmem_wr_data, 32'h1111_0004);
    chk("fd_addr4", dmem_wr_addr, 32'h4010);
    step();
    chk("fd_empty", 32'(sb_empty), 32'd1);

    // reset with three queued entries
    dmem_wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(32'h6000 + 32'(4 * k), 32'hDEAD_0000 + 32'(k), 2'b10);
      step();
    end
    st_valid = 1'b0;
    chk("pre_rst_count", 32'(sb_count), 32'd3);
    reset = 1'b0;
    step();
    chk("mid_rst_count", 32'(sb_count), 32'd0);
    chk("mid_rst_valid", 32'(dmem_wr_valid), 32'd0);
    chk("mid_rst_empty", 32'(sb_empty), 32'd1);
    chk("mid_rst_addr", dmem_wr_addr, 32'd0);
    reset = 1'b1;
    offer(32'h5003, 32'h0000_007E, 2'b00);
    dmem_wr_ready = 1'b1;
    step();
    st_valid = 1'b0;
    chk("post_rst_addr", dmem_wr_addr, 32'h5000);
    chk("post_rst_be", 32'(dmem_wr_be), 32'h8);
    chk("post_rst_data", dmem_wr_data, 32'h7E7E_7E7E);
    step();
    chk("post_rst_empty", 32'(sb_empty), 32'd1);

    // misaligned word store
    offer(32'h3001, 32'hCAFE_F00D, 2'b10);
    step();
    st_valid = 1'b0;
`ifdef BANFF_STORE_MISALIGN_TRAP_EN
    chk("mis_trap", 32'(misalign_trap), 32'd1);
    chk("mis_count", 32'(sb_count), 32'd0);
    chk("mis_valid", 32'(dmem_wr_valid), 32'd0);
    step();
    chk("mis_trap_off", 32'(misalign_trap), 32'd0);
`else
    chk("mis_addr", dmem_wr_addr, 32'h3000);
    chk("mis_be", 32'(dmem_wr_be), 32'hF);
    chk("mis_data", dmem_wr_data, 32'hCAFE_F00D);
    step();
    chk("mis_empty", 32'(sb_empty), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Memory-stage store unit sitting directly downstream of the Execute-stage write-data select mux.
- Accepts one store per handshake: address, selected write data, and size.
- Converts each store into a word-aligned address, lane-replicated data and byte enables.
- Queues stores in a small FIFO store buffer and drains them to data memory over a valid/ready interface.

Parameters:
XLEN, 32, data width in bits; fixed at 32 (4 byte lanes)
ADDR_W, 32, address width in bits
DEPTH, 4, store buffer entries; power of 2, at least 2

Ports:
clock  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
st_valid  input  1  store request valid
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  ADDR_W  byte address of store
st_data  input  XLEN  store data from write-data select mux, right-justified
st_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
dmem_wr_valid  output  1  head entry presented to data memory
dmem_wr_ready  input  1  data memory accepts head entry
dmem_wr_addr  output  ADDR_W  word address; bits [1:0] always 0
dmem_wr_data  output  XLEN  lane-positioned write data
dmem_wr_be  output  4  byte enables, bit i = byte lane i
sb_empty  output  1  buffer holds no entries
sb_count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (reset==0 at a clock edge):
  - Pointers and count cleared; sb_empty=1, sb_count=0.
  - dmem_wr_valid=0; dmem_wr_addr, dmem_wr_data and dmem_wr_be read 0.
  - Reset mid-drain discards all queued entries; no partial write is held.
- Enqueue:
  - Occurs when st_valid && st_ready.
  - st_ready = (sb_count < DEPTH). It depends only on occupancy, never on dmem_wr_ready.
  - When full, no enqueue is accepted, even if a dequeue occurs in the same cycle. There is no pass-through.
- Alignment is computed at enqueue time and stored per entry. With off = st_addr[1:0]:
  - byte: be = 4'b0001<<off; data = {4{st_data[7:0]}}
  - half: be = off[1] ? 4'b1100 : 4'b0011; data = {2{st_data[15:0]}}; off[0] ignored
  - word / size 11: be = 4'b1111; data = st_data; off ignored
  - Stored address = {st_addr[ADDR_W-1:2], 2'b00}.
- Drain:
  - dmem_wr_valid = !sb_empty. Address, data and be come from the head entry register.
  - Dequeue occurs when dmem_wr_valid && dmem_wr_ready.
  - Head outputs are held stable while valid && !ready.
- Latency:
  - A store accepted at edge N is visible on the dmem outputs after edge N, provided the buffer was empty.
  - Stores drain in strict FIFO order, at most one per cycle.
- Simultaneous enqueue and dequeue (not full): sb_count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. sb_count saturates by construction at DEPTH, never exceeding it.
- Data memory is never driven with dmem_wr_valid=1 while empty.

Optional Feature:
- Macro: BANFF_STORE_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_trap (1 bit, registered, reset 0).
  - A store is misaligned when half has off[0]=1, or word/11 has off!=0.
  - A misaligned store offered with st_valid && st_ready is consumed (handshake completes) but is NOT enqueued.
  - misalign_trap pulses 1 for exactly the cycle after acceptance.
- Not defined:
  - No misalign_trap port.
  - Misaligned low bits are ignored per the alignment rules above, and the store is enqueued.

Test Plan:
- Byte stores at addr 0x1000..0x1003, data 0xA5, dmem_wr_ready=1 -> four writes to 0x1000 with be 0001, 0010, 0100, 1000, each with data 0xA5A5A5A5, in order.
- Half store at addr 0x2002, data 0x0000BEEF -> addr 0x2000, be 1100, data 0xBEEFBEEF. Word store at 0x2004, data 0x12345678 -> be 1111, data 0x12345678.
- Hold dmem_wr_ready=0 and offer 5 word stores -> first 4 accepted, st_ready=0 with sb_count=4, 5th stalls, head outputs stable. Raise ready -> all 5 drain in order.
- Full buffer with st_valid=1 and dmem_wr_ready=1 in the same cycle -> dequeue occurs, no enqueue that cycle; st_ready=1 next cycle.
- Assert reset=0 with 3 entries queued -> next cycle sb_count=0, dmem_wr_valid=0, sb_empty=1. Deassert, then a new store drains normally.
- With BANFF_STORE_MISALIGN_TRAP_EN defined: word store at 0x3001 -> misalign_trap=1 for one cycle, sb_count unchanged. Without the macro: write to 0x3000 with be 1111.
